rng_sched: RTL and testbench
============================

RNG_SCHED -- requirements
Module: rng_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the random stream (2..8).
REQ-002 Parameter WARMUP, default 8, cycles of LFSR output discarded after every (re)seed (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 seed_in  input  32  seed value, sampled on reset and on reseed.
REQ-006 reseed  input  1  one-cycle pulse requesting a new seed sequence.
REQ-007 rnd1  input  32  first LFSR word from the shared generator.
REQ-008 rnd2  input  32  second LFSR word from the shared generator.
REQ-009 rng_seed  output  32  seed driven to the shared generator.
REQ-010 rng_reset  output  1  reset driven to the shared generator.
REQ-011 req  input  N_REQ  per-requester request level, held until granted.
REQ-012 gnt  output  N_REQ  one-hot grant; rnd_out valid for the granted requester.
REQ-013 rnd_out  output  64  {rnd2, rnd1} captured in the grant cycle.
REQ-014 busy  output  1  high while not in SERVE.

Function
REQ-015 FSM states SEED, WARMUP, SERVE, encoded as a package enum.
REQ-016 SEED: lasts exactly 1 cycle; rng_reset=1, rng_seed=latched seed; next state WARMUP with warm-up counter=WARMUP-1.
REQ-017 WARMUP: rng_reset=0; counter decrements each cycle; at 0, next state SERVE.
REQ-018 SERVE: each cycle, if any req bit set, grant exactly one requester, round-robin starting at index after last grantee (index 0 first after reset/reseed).
REQ-019 gnt and rnd_out are registered: req sampled at edge k gives gnt/rnd_out visible in cycle k+1 (latency 1); gnt lasts 1 cycle.
REQ-020 A requester whose req remains high after a grant is re-eligible next cycle but loses priority to other pending requesters.
REQ-021 No req set -> gnt=0, rnd_out holds last value, pointer unchanged.
REQ-022 gnt=0 in SEED and WARMUP regardless of req; pending requests are served once SERVE is entered.
REQ-023 reseed in any state: latch seed_in, go to SEED next cycle; a grant in that same cycle is suppressed; pointer resets to 0.
REQ-024 reseed during SEED or WARMUP restarts the full sequence with the new seed.
REQ-025 busy=1 exactly in SEED and WARMUP.

Reset
REQ-026 While reset=1: state SEED, seed latch <= seed_in, gnt=0, rnd_out=0, pointer=0, busy=1, rng_reset=1, rng_seed=seed_in.
REQ-027 First cycle after reset deasserts is the single SEED cycle of REQ-016; reset overrides reseed.

Configuration
REQ-028 Macro RNG_SCHED_STATS_EN: when defined, output grant_count (16 bits) counts grants in SERVE, wraps 0xFFFF->0, cleared by reset and reseed.
REQ-029 Without RNG_SCHED_STATS_EN: port grant_count and its counter do not exist; all other behaviour identical.

Structure
REQ-030 Package rng_pkg holds the state enum type, default WARMUP, and the 64-bit random-word typedef.
REQ-031 Round-robin selection is a sub-module rr_arbiter (req, pointer -> one-hot grant, next pointer), purely combinational.
REQ-032 rng_sched connects to one external rng instance via rng_seed/rng_reset/rnd1/rnd2; it does not instantiate it.

Verification
REQ-033 Reset with seed_in=0x1234_5678, WARMUP=8 -> rng_reset high 1 cycle after reset release, busy low exactly 9 cycles after release, rng_seed=0x1234_5678.
REQ-034 req=4'b1111 held in SERVE -> gnt sequence 0001,0010,0100,1000,0001; rnd_out equals {rnd2,rnd1} of each sampling cycle.
REQ-035 req=4'b0101 held -> gnt alternates 0001,0100; bits 1,3 never granted.
REQ-036 reseed pulse with seed_in=0xDEAD_BEEF while req=4'b0001 -> no gnt that cycle, busy high 1+WARMUP cycles, next gnt=0001 after SERVE entry, rng_seed=0xDEAD_BEEF.
REQ-037 reseed repeated mid-WARMUP (counter=3) -> SEED re-entered next cycle, full WARMUP repeated.
REQ-038 With RNG_SCHED_STATS_EN, 65537 grants -> grant_count=1; reseed -> grant_count=0.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types for the random-number scheduler: FSM states, default warm-up
// length and the 64-bit random word handed to requesters.
package rng_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SERVE  = 2'd2
    } state_e;

    localparam int DEFAULT_WARMUP = 8;

    typedef logic [63:0] rnd_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req_i starting at ptr_i and
// returns a one-hot grant plus the pointer just past the winner.
module rr_arbiter
    import rng_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    next_ptr_o
);

    logic          found;
    logic [PW-1:0] sel;

    // First set request at or after the pointer wins; pointer is held when idle.
    always_comb begin
        gnt_o      = '0;
        next_ptr_o = ptr_i;
        found      = 1'b0;
        sel        = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sel = PW'((int'(ptr_i) + off) % N_REQ);
            if (!found && req_i[sel]) begin
                gnt_o[sel] = 1'b1;
                next_ptr_o = PW'((int'(sel) + 1) % N_REQ);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_sched.sv
// Seeds and warms up an external LFSR, then hands its output to N_REQ requesters
// round-robin. Optional grant counter enabled by macro RNG_SCHED_STATS_EN.
module rng_sched
    import rng_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WARMUP = DEFAULT_WARMUP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      seed_in,
    input  logic             reseed,
    input  logic [31:0]      rnd1,
    input  logic [31:0]      rnd2,
    output logic [31:0]      rng_seed,
    output logic             rng_reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [63:0]      rnd_out,
    output logic             busy
`ifdef RNG_SCHED_STATS_EN
    ,
    output logic [15:0]      grant_count
`endif
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = 8;

    state_e            state_q, state_d;
    logic [31:0]       seed_q, seed_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    rnd_word_t         rnd_q, rnd_d;
    logic [N_REQ-1:0]  arbGnt;
    logic [PW-1:0]     arbNextPtr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .gnt_o      (arbGnt),
        .next_ptr_o (arbNextPtr)
    );

    // A reseed pre-empts everything, including a grant that would issue this cycle.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        rnd_d   = rnd_q;
        if (reseed) begin
            seed_d  = seed_in;
            state_d = ST_SEED;
            ptr_d   = '0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    state_d = ST_WARMUP;
                    cnt_d   = CW'(WARMUP - 1);
                end
                ST_WARMUP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (|req) begin
                        gnt_d = arbGnt;
                        ptr_d = arbNextPtr;
                        rnd_d = {rnd2, rnd1};
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SEED;
            seed_q  <= seed_in;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
        end
    end

    assign rng_seed  = reset ? seed_in : seed_q;
    assign rng_reset = reset | (state_q == ST_SEED);
    assign busy      = reset | (state_q != ST_SERVE);
    assign gnt       = gnt_q;
    assign rnd_out   = rnd_q;

`ifdef RNG_SCHED_STATS_EN
    logic [15:0] grantCnt_q, grantCnt_d;

    always_comb begin
        grantCnt_d = grantCnt_q;
        if (reseed) begin
            grantCnt_d = '0;
        end else if (|gnt_d) begin
            grantCnt_d = grantCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grantCnt_q <= '0;
        end else begin
            grantCnt_q <= grantCnt_d;
        end
    end

    assign grant_count = grantCnt_q;
`endif

endmodule

// File: tb/tb_rng_sched.sv
// Self-checking bench for rng_sched: reset/seed timing, a table of round-robin
// vectors scored through a queue, and hand-written reseed sequences.
module tb_rng_sched;

    logic        clk;
    logic        reset;
    logic [31:0] seed_in;
    logic        reseed;
    logic [31:0] rnd1;
    logic [31:0] rnd2;
    logic [31:0] rng_seed;
    logic        rng_reset;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [63:0] rnd_out;
    logic        busy;
`ifdef RNG_SCHED_STATS_EN
    logic [15:0] grant_count;
`endif

    int compared = 0;
    int failed   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] expGnt;
    } vec_t;

    typedef struct {
        logic [3:0]  gnt;
        logic [63:0] rnd;
    } exp_t;

    vec_t        vecs[17];
    exp_t        sbq[$];
    exp_t        e;
    logic [63:0] expRnd;
    int          n;

    rng_sched #(
        .N_REQ  (4),
        .WARMUP (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seed_in     (seed_in),
        .reseed      (reseed),
        .rnd1        (rnd1),
        .rnd2        (rnd2),
        .rng_seed    (rng_seed),
        .rng_reset   (rng_reset),
        .req         (req),
        .gnt         (gnt),
        .rnd_out     (rnd_out),
        .busy        (busy)
`ifdef RNG_SCHED_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rs);
        req    = r;
        reseed = rs;
        rnd1   = $urandom;
        rnd2   = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles spent busy from the current (SEED) cycle; gnt must stay low throughout.
    task automatic countBusy(output int cycles);
        cycles = 0;
        while (busy && cycles < 50) begin
            checkOutput("gnt_while_busy", {60'd0, gnt}, 64'd0);
            tick();
            cycles++;
        end
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0010};
        vecs[2]  = '{4'b1111, 4'b0100};
        vecs[3]  = '{4'b1111, 4'b1000};
        vecs[4]  = '{4'b1111, 4'b0001};
        vecs[5]  = '{4'b0101, 4'b0100};
        vecs[6]  = '{4'b0101, 4'b0001};
        vecs[7]  = '{4'b0101, 4'b0100};
        vecs[8]  = '{4'b0101, 4'b0001};
        vecs[9]  = '{4'b0000, 4'b0000};
        vecs[10] = '{4'b1000, 4'b1000};
        vecs[11] = '{4'b1000, 4'b1000};
        vecs[12] = '{4'b1001, 4'b0001};
        vecs[13] = '{4'b1001, 4'b1000};
        vecs[14] = '{4'b0110, 4'b0010};
        vecs[15] = '{4'b0000, 4'b0000};
        vecs[16] = '{4'b0010, 4'b0010};

        reset   = 1'b1;
        seed_in = 32'h1234_5678;
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();
        checkOutput("reset_gnt", {60'd0, gnt}, 64'd0);
        checkOutput("reset_rnd_out", rnd_out, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd1);
        checkOutput("reset_rng_reset", {63'd0, rng_reset}, 64'd1);
        checkOutput("reset_rng_seed", {32'd0, rng_seed}, {32'd0, 32'h1234_5678});

        // Release reset with every requester pending: nothing may be granted until SERVE.
        reset = 1'b0;
        applyStimulus(4'b1111, 1'b0);
        #1;
        checkOutput("seed_rng_reset", {63'd0, rng_reset}, 64'd1);
        checkOutput("seed_rng_seed", {32'd0, rng_seed}, {32'd0, 32'h1234_5678});
        countBusy(n);
        checkOutput("reset_busy_cycles", 64'(n), 64'd9);
        checkOutput("serve_entry_rng_reset", {63'd0, rng_reset}, 64'd0);
        checkOutput("serve_entry_gnt", {60'd0, gnt}, 64'd0);
        checkOutput("serve_entry_rnd_out", rnd_out, 64'd0);

        expRnd = 64'd0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].req, 1'b0);
            if (vecs[i].expGnt != 4'b0000) begin
                expRnd = {rnd2, rnd1};
            end
            e.gnt = vecs[i].expGnt;
            e.rnd = expRnd;
            sbq.push_back(e);
            tick();
            if (sbq.size() == 0) begin
                checkOutput("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput($sformatf("vec%0d_gnt", i), {60'd0, gnt}, {60'd0, e.gnt});
                checkOutput($sformatf("vec%0d_rnd_out", i), rnd_out, e.rnd);
            end
        end

        // Reseed while a request is pending: the grant for this cycle is dropped.
        seed_in = 32'hDEAD_BEEF;
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkOutput("reseed_gnt", {60'd0, gnt}, 64'd0);
        checkOutput("reseed_rng_seed", {32'd0, rng_seed}, {32'd0, 32'hDEAD_BEEF});
        checkOutput("reseed_rng_reset", {63'd0, rng_reset}, 64'd1);
        seed_in = 32'h0;
        applyStimulus(4'b0001, 1'b0);
        countBusy(n);
        checkOutput("reseed_busy_cycles", 64'(n), 64'd9);
        checkOutput("reseed_seed_held", {32'd0, rng_seed}, {32'd0, 32'hDEAD_BEEF});
        tick();
        checkOutput("reseed_first_gnt", {60'd0, gnt}, 64'd1);
        applyStimulus(4'b1111, 1'b0);
        tick();
        checkOutput("reseed_rr_gnt", {60'd0, gnt}, 64'd2);

        // Reseed again, then once more when the warm-up counter has reached 3.
        seed_in = 32'hCAFE_F00D;
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("reseed2_gnt", {60'd0, gnt}, 64'd0);
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("warmup_busy", {63'd0, busy}, 64'd1);
        end
        checkOutput("warmup_rng_reset", {63'd0, rng_reset}, 64'd0);
        seed_in = 32'h0BAD_F00D;
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("midwarm_rng_reset", {63'd0, rng_reset}, 64'd1);
        checkOutput("midwarm_rng_seed", {32'd0, rng_seed}, {32'd0, 32'h0BAD_F00D});
        applyStimulus(4'b1111, 1'b0);
        countBusy(n);
        checkOutput("midwarm_busy_cycles", 64'(n), 64'd9);
        tick();
        checkOutput("ptr_reset_gnt0", {60'd0, gnt}, 64'd1);
        tick();
        checkOutput("ptr_reset_gnt1", {60'd0, gnt}, 64'd2);

`ifdef RNG_SCHED_STATS_EN
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("stats_clear", {48'd0, grant_count}, 64'd0);
        applyStimulus(4'b0000, 1'b0);
        countBusy(n);
        req = 4'b1111;
        for (int i = 0; i < 65537; i++) begin
            tick();
        end
        req = 4'b0000;
        tick();
        checkOutput("stats_wrap", {48'd0, grant_count}, 64'd1);
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("stats_reseed_clear", {48'd0, grant_count}, 64'd0);
        reseed = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
